// File: rtl/conv_encoder_r12_if.sv
// conv_encoder_r12_if
//   Stream bundle for the rate-1/2 convolutional encoder.
//   Input side : in_bit, in_valid, in_last (to encoder), in_ready (from encoder)
//   Output side: out_sym[1:0], out_valid, out_last (from encoder), out_ready (to encoder)
//   master : the surrounding logic that feeds bits in and takes symbols out
//   slave  : the encoder itself
interface conv_encoder_r12_if;
  logic       in_bit;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [1:0] out_sym;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;

  modport master (
    output in_bit, in_valid, in_last, out_ready,
    input  in_ready, out_sym, out_valid, out_last
  );

  modport slave (
    input  in_bit, in_valid, in_last, out_ready,
    output in_ready, out_sym, out_valid, out_last
  );
endinterface

// File: rtl/conv_encoder_r12.sv
// conv_encoder_r12
//   Rate-1/2 feed-forward convolutional encoder, constraint length K.
//   Each accepted data bit produces one 2-bit symbol {parity G0, parity G1}.
//   A bit flagged in_last is followed by K-1 zero tail symbols, so every frame
//   finishes in trellis state 0. The final tail symbol carries out_last.
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : conv_encoder_r12_if.slave (input bit stream, output symbol stream)
//
// state  | meaning
// S_DATA | accepting data bits, one symbol per accepted bit
// S_TAIL | flushing K-1 zero bits, input stalled
module conv_encoder_r12 #(
  parameter int             K  = 3,
  parameter logic [K-1:0]   G0 = 3'b111,
  parameter logic [K-1:0]   G1 = 3'b101
) (
  input  logic              clk,
  input  logic              rst,
  conv_encoder_r12_if.slave bus
);

  localparam int CW = $clog2(K) + 1;

  typedef enum logic {S_DATA, S_TAIL} state_t;

  state_t        state;
  logic [K-2:0]  sr;
  logic [CW-1:0] tail_cnt;

  logic          slot_free;
  logic          accept;
  logic          tail_step;
  logic          load;
  logic          u;
  logic [K-1:0]  t;
  logic [K-2:0]  sr_shift;

  // The output register can take a new symbol when empty or being drained.
  assign slot_free    = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = (state == S_DATA) & slot_free & !rst;
  assign accept       = bus.in_valid & bus.in_ready;
  assign tail_step    = (state == S_TAIL) & slot_free;
  assign load         = accept | tail_step;

  assign u = (state == S_DATA) ? bus.in_bit : 1'b0;
  assign t = {u, sr};

  // New bit enters at the top; the oldest bit falls off sr[0].
  // Written as shift-then-overwrite so it also holds for K=2.
  always_comb begin
    sr_shift       = sr >> 1;
    sr_shift[K-2]  = u;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_DATA;
      sr            <= '0;
      tail_cnt      <= '0;
      bus.out_sym   <= 2'b00;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
    end else begin
      if (load) begin
        bus.out_sym   <= {^(t & G0), ^(t & G1)};
        bus.out_valid <= 1'b1;
        bus.out_last  <= tail_step && (tail_cnt == CW'(1));
        sr            <= sr_shift;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end

      case (state)
        S_DATA: begin
          if (accept && bus.in_last) begin
            tail_cnt <= CW'(K - 1);
            state    <= S_TAIL;
          end
        end
        S_TAIL: begin
          if (slot_free) begin
            tail_cnt <= tail_cnt - CW'(1);
            if (tail_cnt == CW'(1)) state <= S_DATA;
          end
        end
        default: state <= S_DATA;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_r12.sv
// tb_conv_encoder_r12
//   Directed table of frames with hand-computed symbols for K=3, G0=111,
//   G1=101, then reset-abort and random-frame sequences checked against a
//   small reference encoder. Symbols are logged as {sym[1], sym[0], last}.
module tb_conv_encoder_r12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  conv_encoder_r12_if bus ();

  conv_encoder_r12 #(.K(3), .G0(3'b111), .G1(3'b101)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          n;       // input bits in this record
    logic [7:0]  bit_v;   // bit j at [7-j]
    logic [7:0]  last_v;  // in_last for bit j at [7-j]
    int          nexp;    // expected symbol count
    logic [29:0] exp_v;   // symbol j at [29-3j -: 3], {s1,s0,last}
    int          mode;    // out_ready: 0 always, 1 toggling, 2 random
    int          rdy0;    // expected in_ready-low cycles, -1 = not checked
  } vec_t;

  vec_t       tv [4];
  int         n_vec = 0;
  int         n_err = 0;
  logic       in_q   [$];
  logic       last_q [$];
  logic [2:0] exp_q  [$];
  logic [2:0] got    [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Drive queued bits, collect symbols, check hold-under-backpressure.
  task automatic run(input int mode, input int budget, input int exp_rdy0);
    int         cyc  = 0;
    int         rdy0 = 0;
    logic       hold = 1'b0;
    logic [2:0] ph   = 3'b000;
    got.delete();
    while ((in_q.size() > 0 || got.size() < exp_q.size()) && cyc < budget) begin
      @(negedge clk);
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 2 == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (in_q.size() > 0) begin
        bus.in_valid = 1'b1;
        bus.in_bit   = in_q[0];
        bus.in_last  = last_q[0];
      end else begin
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        bus.in_last  = 1'b0;
      end
      #1;
      if (hold) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_sym", 32'({bus.out_sym, bus.out_last}), 32'(ph));
      end
      if (bus.out_valid && !bus.out_ready)
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      if (!bus.in_ready) rdy0++;
      if (bus.out_valid && bus.out_ready) got.push_back({bus.out_sym, bus.out_last});
      if (bus.in_valid && bus.in_ready) begin
        void'(in_q.pop_front());
        void'(last_q.pop_front());
      end
      hold = bus.out_valid && !bus.out_ready;
      ph   = {bus.out_sym, bus.out_last};
      cyc++;
    end
    if (cyc >= budget) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: got %0d symbols after %0d cycles, expected %0d", got.size(), cyc, exp_q.size());
      in_q.delete();
      last_q.delete();
    end
    chk("sym_count", 32'(got.size()), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < got.size(); j++)
      chk($sformatf("sym[%0d]", j), 32'(got[j]), 32'(exp_q[j]));
    if (exp_rdy0 >= 0) chk("in_ready_low_cycles", 32'(rdy0), 32'(exp_rdy0));
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("in_ready_after", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
  endtask

  // Reference: for G0=111, G1=101 the parities are u^p1^p2 and u^p2,
  // with p1 the previous bit and p2 the one before it.
  task automatic model_frame(input int len);
    logic p1 = 1'b0;
    logic p2 = 1'b0;
    logic u;
    for (int j = 0; j < len + 2; j++) begin
      if (j < len) begin
        u = 1'($urandom_range(0, 1));
        in_q.push_back(u);
        last_q.push_back(j == len - 1);
      end else begin
        u = 1'b0;
      end
      exp_q.push_back({u ^ p1 ^ p2, u ^ p2, (j == len + 1)});
      p2 = p1;
      p1 = u;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{4, 8'b1011_0000, 8'b0001_0000, 6,
              {3'b110, 3'b100, 3'b000, 3'b010, 3'b010, 3'b111, 12'b0}, 0, 2};
    tv[1] = '{1, 8'b1000_0000, 8'b1000_0000, 3,
              {3'b110, 3'b100, 3'b111, 21'b0}, 0, 2};
    tv[2] = '{4, 8'b1011_0000, 8'b0001_0000, 6,
              {3'b110, 3'b100, 3'b000, 3'b010, 3'b010, 3'b111, 12'b0}, 1, -1};
    tv[3] = '{3, 8'b1110_0000, 8'b0110_0000, 7,
              {3'b110, 3'b010, 3'b010, 3'b111, 3'b110, 3'b100, 3'b111, 9'b0}, 0, 4};

    bus.in_bit    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sym", 32'(bus.out_sym), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < tv[i].n; j++) begin
        in_q.push_back(tv[i].bit_v[7-j]);
        last_q.push_back(tv[i].last_v[7-j]);
      end
      for (int j = 0; j < tv[i].nexp; j++)
        exp_q.push_back(tv[i].exp_v[29-3*j -: 3]);
      run(tv[i].mode, 200, tv[i].rdy0);
    end

    // Reset two bits into a frame: nothing pending, shift register cleared.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_bit    = 1'b1;
    bus.in_last   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    in_q.push_back(1'b1);
    last_q.push_back(1'b1);
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b111);
    run(0, 50, 2);

    // Random frames with random backpressure.
    for (int f = 0; f < 6; f++) model_frame($urandom_range(1, 64));
    run(2, 5000, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
